// File: rtl/gxb_tx_fpll_reconfig_master.sv
// Avalon-MM initiator for TX fPLL reconfiguration: plain write or masked RMW,
// with an optional recalibration/lock handshake and one status response per command.
module gxb_tx_fpll_reconfig_master #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CAL_START_WIN = 64,
  parameter int unsigned CAL_TIMEOUT   = 500000,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned LOCK_STABLE   = 16
) (
  input  logic              reconfig_clk,
  input  logic              reconfig_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rmw,
  input  logic              cmd_cal,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_mask,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              reconfig_write,
  output logic              reconfig_read,
  output logic [ADDR_W-1:0] reconfig_address,
  output logic [DATA_W-1:0] reconfig_writedata,
  input  logic [DATA_W-1:0] reconfig_readdata,
  input  logic              reconfig_waitrequest,
  input  logic              pll_cal_busy,
  input  logic              pll_locked
);

  localparam int unsigned MAX_TO = (CAL_TIMEOUT > LOCK_TIMEOUT) ? CAL_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned MAX_T  = (MAX_TO > CAL_START_WIN) ? MAX_TO : CAL_START_WIN;
  localparam int unsigned CNT_W  = $clog2(MAX_T + 1);
  localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_CAL_START, S_CAL_RUN, S_LOCK, S_RSP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   mask_q, mask_d, data_q, data_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rd_q, rd_d;
  logic                cal_q, cal_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [1:0]          rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          cal_sync_q, lock_sync_q;
  logic                cal_s, lock_s;

  assign cal_s  = cal_sync_q[1];
  assign lock_s = lock_sync_q[1];

  always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
    if (!reconfig_reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      mask_q       <= '0;
      data_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      cal_q        <= 1'b0;
      cnt_q        <= '0;
      stab_q       <= '0;
      rsp_status_q <= '0;
      rsp_rdata_q  <= '0;
      cal_sync_q   <= '0;
      lock_sync_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      data_q       <= data_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      cal_q        <= cal_d;
      cnt_q        <= cnt_d;
      stab_q       <= stab_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
      cal_sync_q   <= {cal_sync_q[0], pll_cal_busy};
      lock_sync_q  <= {lock_sync_q[0], pll_locked};
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    data_d       = data_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    cal_d        = cal_q;
    cnt_d        = cnt_q;
    stab_d       = stab_q;
    rsp_status_d = rsp_status_q;
    rsp_rdata_d  = rsp_rdata_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        mask_d  = cmd_mask;
        data_d  = cmd_data;
        wdata_d = cmd_data;
        rd_d    = '0;
        cal_d   = cmd_cal;
        state_d = cmd_rmw ? S_RD : S_WR;
      end
      S_RD: if (!reconfig_waitrequest) begin
        rd_d    = reconfig_readdata;
        wdata_d = (reconfig_readdata & ~mask_q) | (data_q & mask_q);
        state_d = S_WR;
      end
      S_WR: if (!reconfig_waitrequest) begin
        cnt_d        = '0;
        stab_d       = '0;
        rsp_status_d = 2'd0;
        state_d      = cal_q ? S_CAL_START : S_RSP;
      end
      S_CAL_START: begin
        if (cal_s) begin
          cnt_d   = '0;
          state_d = S_CAL_RUN;
        end else if (cnt_q == CNT_W'(CAL_START_WIN - 1)) begin
          rsp_status_d = 2'd1;
          state_d      = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAL_RUN: begin
        if (!cal_s) begin
          cnt_d   = '0;
          stab_d  = '0;
          state_d = S_LOCK;
        end else if (cnt_q == CNT_W'(CAL_TIMEOUT - 1)) begin
          rsp_status_d = 2'd2;
          state_d      = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOCK: begin
        // Stable lock is tested first so it wins over a coincident timeout.
        if (lock_s && stab_q == STAB_W'(LOCK_STABLE - 1)) begin
          rsp_status_d = 2'd0;
          state_d      = S_RSP;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          rsp_status_d = 2'd3;
          state_d      = S_RSP;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          stab_d = lock_s ? stab_q + 1'b1 : '0;
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RSP && state_q != S_RSP) rsp_rdata_d = rd_q;
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign busy               = (state_q != S_IDLE);
  assign reconfig_read      = (state_q == S_RD);
  assign reconfig_write     = (state_q == S_WR);
  assign reconfig_address   = addr_q;
  assign reconfig_writedata = wdata_q;
  assign rsp_valid          = (state_q == S_RSP);
  assign rsp_status         = rsp_status_q;
  assign rsp_rdata          = rsp_rdata_q;

endmodule

// File: tb/tb_gxb_tx_fpll_reconfig_master.sv
// Scoreboard bench for gxb_tx_fpll_reconfig_master with a small Avalon slave model.
module tb_gxb_tx_fpll_reconfig_master;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_rmw, cmd_cal;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_mask, cmd_data;
  logic        rsp_valid, busy;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic        wr, rd;
  logic [9:0]  address;
  logic [31:0] writedata, readdata;
  logic        waitrequest;
  logic        cal_busy, locked;

  gxb_tx_fpll_reconfig_master #(.CAL_TIMEOUT(300), .LOCK_TIMEOUT(400)) dut (
    .reconfig_clk(clk), .reconfig_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rmw(cmd_rmw), .cmd_cal(cmd_cal),
    .cmd_addr(cmd_addr), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata), .busy(busy),
    .reconfig_write(wr), .reconfig_read(rd), .reconfig_address(address),
    .reconfig_writedata(writedata), .reconfig_readdata(readdata),
    .reconfig_waitrequest(waitrequest), .pll_cal_busy(cal_busy), .pll_locked(locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang required completion");
    $fatal(1);
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Avalon slave model: stalls each access for a programmable number of cycles.
  int unsigned rd_wait = 0, wr_wait = 0, hold_cnt = 0;
  int unsigned rd_cycles = 0, wr_cycles = 0, wr_cnt = 0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  always_comb waitrequest = (rd && hold_cnt < rd_wait) || (wr && hold_cnt < wr_wait);

  always @(posedge clk) begin
    if ((rd || wr) && waitrequest) hold_cnt <= hold_cnt + 1;
    else                           hold_cnt <= 0;
    if (rd) rd_cycles <= rd_cycles + 1;
    if (wr) wr_cycles <= wr_cycles + 1;
    if (wr && !waitrequest) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= address;
      wr_data <= writedata;
    end
  end

  typedef struct {
    logic [1:0]  st;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    exp_t e;
    check("rd_wr_exclusive", 64'(rd & wr), 64'd0);
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_status", 64'(rsp_status), 64'(e.st));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      end
    end
  end

  task automatic issue(input logic rmw, input logic cal, input logic [9:0] a,
                       input logic [31:0] m, input logic [31:0] d,
                       input bit expect_rsp, input logic [1:0] st, input logic [31:0] rdx);
    int unsigned n = 0;
    exp_t e;
    @(negedge clk);
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_rmw = rmw; cmd_cal = cal;
    cmd_addr = a; cmd_mask = m; cmd_data = d;
    if (expect_rsp) begin
      e.st = st;
      e.rdata = rdx;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned max);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < max);
    check("done_in_time", 64'(cmd_ready), 64'd1);
  endtask

  task automatic wait_write_cycle();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr && !waitrequest) && n < 100);
    check("write_seen", 64'(wr), 64'd1);
  endtask

  int unsigned base_rd, base_wr, base_cnt, k;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rmw = 1'b0; cmd_cal = 1'b0;
    cmd_addr = '0; cmd_mask = '0; cmd_data = '0;
    readdata = '0; cal_busy = 1'b0; locked = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({cmd_ready, rsp_valid, busy, rd, wr, rsp_status}), 64'b1000000);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_addr", 64'(address), 64'd0);
    check("rst_wdata", 64'(writedata), 64'd0);
    rst_n = 1'b1;

    // Plain write, zero wait states.
    base_cnt = wr_cnt; base_rd = rd_cycles;
    issue(1'b0, 1'b0, 10'h100, 32'hFFFF_0000, 32'hA5A5_0000, 1'b1, 2'd0, 32'h0);
    @(negedge clk);
    check("pw_write_c1", 64'({wr, rd, rsp_valid}), 64'b100);
    check("pw_addr", 64'(address), 64'h100);
    check("pw_wdata", 64'(writedata), 64'hA5A5_0000);
    @(negedge clk);
    check("pw_rsp_c2", 64'({rsp_valid, wr, cmd_ready}), 64'b100);
    @(negedge clk);
    check("pw_ready_c3", 64'(cmd_ready), 64'd1);
    check("pw_write_count", 64'(wr_cnt - base_cnt), 64'd1);
    check("pw_no_read", 64'(rd_cycles - base_rd), 64'd0);

    // Read-modify-write with 3 wait states on both phases.
    rd_wait = 3; wr_wait = 3; readdata = 32'hFFFF_0000;
    base_rd = rd_cycles; base_wr = wr_cycles;
    issue(1'b1, 1'b0, 10'h2A4, 32'h0000_00FF, 32'h0000_0012, 1'b1, 2'd0, 32'hFFFF_0000);
    wait_done(50);
    check("rmw_rd_cycles", 64'(rd_cycles - base_rd), 64'd4);
    check("rmw_wr_cycles", 64'(wr_cycles - base_wr), 64'd4);
    check("rmw_wdata", 64'(wr_data), 64'hFFFF_0012);
    check("rmw_addr", 64'(wr_addr), 64'h2A4);
    rd_wait = 0; wr_wait = 0;

    // Calibration and lock success; locked rise to rsp_valid is LOCK_STABLE+2 edges.
    issue(1'b0, 1'b1, 10'h010, 32'h0, 32'h1, 1'b1, 2'd0, 32'h0);
    wait_write_cycle();
    repeat (10) @(posedge clk);
    #1 cal_busy = 1'b1;
    repeat (200) @(posedge clk);
    #1 cal_busy = 1'b0;
    repeat (50) @(posedge clk);
    #1 locked = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
    end while (!rsp_valid && k < 100);
    check("lock_latency", 64'(k), 64'd18);
    wait_done(10);
    locked = 1'b0;

    // Calibration never starts: 64 cycles in CAL_START, then status 1.
    issue(1'b0, 1'b1, 10'h011, 32'h0, 32'h2, 1'b1, 2'd1, 32'h0);
    wait_write_cycle();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 200);
    check("nostart_latency", 64'(k), 64'd65);
    wait_done(10);

    // Calibration busy stuck high: status 2.
    cal_busy = 1'b1;
    repeat (3) @(posedge clk);
    issue(1'b0, 1'b1, 10'h012, 32'h0, 32'h3, 1'b1, 2'd2, 32'h0);
    wait_done(1000);
    cal_busy = 1'b0;
    repeat (3) @(posedge clk);

    // Lock toggling every 8 cycles never becomes stable: status 3.
    issue(1'b0, 1'b1, 10'h013, 32'h0, 32'h4, 1'b1, 2'd3, 32'h0);
    wait_write_cycle();
    repeat (5) @(posedge clk);
    #1 cal_busy = 1'b1;
    repeat (20) @(posedge clk);
    #1 cal_busy = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat (8) @(posedge clk);
          #1 locked = ~locked;
        end
      end
      wait_done(1000);
    join
    locked = 1'b0;

    // Asynchronous reset while a read is stalled: no response for that command.
    rd_wait = 1000; readdata = 32'hDEAD_BEEF;
    issue(1'b1, 1'b0, 10'h055, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'd0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_pre_read", 64'(rd), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_read", 64'({rd, wr, cmd_ready, busy}), 64'b0010);
    @(negedge clk);
    rst_n = 1'b1;
    rd_wait = 0;
    @(negedge clk);
    check("rst_ready_after", 64'(cmd_ready), 64'd1);
    issue(1'b0, 1'b0, 10'h3FF, 32'h0, 32'h1234_5678, 1'b1, 2'd0, 32'h0);
    wait_done(20);
    check("post_rst_addr", 64'(wr_addr), 64'h3FF);
    check("post_rst_wdata", 64'(wr_data), 64'h1234_5678);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
